bus_grant_controller: RTL and testbench
=======================================

Name: bus_grant_controller

Overview:
Time-sliced round-robin bus controller for the shared processor/memory bus used by the four accumulator processors. It grants the bus to one requester at a time and holds the grant for as long as that requester keeps requesting, up to a quantum. A requester is preempted at the quantum only if others are waiting. Each grant is followed by a fixed turnaround gap, so two tri-state drivers never overlap on the shared read/write lines.

Parameters:
N_REQ, 4, number of requesters (width of req/grant); the design is verified at 4
QUANTUM, 16, maximum consecutive grant cycles before preemption when others are waiting; must be >= 1
GAP_CYCLES, 1, bus-idle cycles (grant = 0) after every grant release; must be >= 1
CNT_W, 5, width of the internal hold counter; must satisfy 2^CNT_W > QUANTUM

Ports:
clk  input  1  bus clock, all state updates on its rising edge
reset  input  1  synchronous, active-low reset (0 at a rising edge of clk resets the block)
req  input  N_REQ  request lines, one per processor, level-sensitive
grant  output  N_REQ  one-hot or zero; registered
owner  output  2  index of current grantee; valid only while busy = 1
busy  output  1  1 while any grant bit is set
expired  output  1  one-cycle pulse when a grant is removed by quantum preemption
hold_count  output  CNT_W  number of cycles the current grant has been held, minus 1; 0 when not busy

Behaviour:
- Reset (reset = 0 at edge): state IDLE; grant = 0, owner = 0, busy = 0, expired = 0, hold_count = 0; gap counter = 0; last pointer = N_REQ-1, so req[0] has first priority.
- All outputs are registered. No combinational path from req to grant.
- Arbitration function: search circularly from (last+1) mod N_REQ and select the first set req bit. On a win, last <= winner.
- IDLE:
  - If req != 0 at an edge: go to GRANT; grant <= one-hot(winner); owner <= winner; hold_count <= 0.
  - Latency from req sampled to grant visible is exactly 1 cycle.
- GRANT, each edge:
  - If req[owner] = 0: release. grant <= 0; go to GAP.
  - Else if hold_count = QUANTUM-1 and any other req bit is set: preempt. grant <= 0; expired <= 1 for that one cycle; go to GAP.
  - Else: keep the grant. hold_count increments, saturating at QUANTUM-1. A lone requester keeps the bus indefinitely.
  - Release takes priority over preemption when both apply on the same edge; expired is not pulsed.
- GAP:
  - grant = 0 and busy = 0 for exactly GAP_CYCLES cycles.
  - On the edge ending the last gap cycle, arbitrate on the req value sampled at that edge. With a winner, go to GRANT (grant visible in the next cycle); with no requester, go to IDLE.
  - The released owner competes at lowest priority, because last = owner.
- Requests from non-owners during GRANT or GAP are not latched. A req pulse that drops before being sampled in IDLE or at the end of a gap is lost; requesters hold req until granted.
- Owner drops req and re-asserts it in the same cycle it is sampled low: the release still happens and the owner is re-arbitrated after the gap.
- Reset mid-GRANT or mid-GAP: grant drops to 0 at that edge, expired is cleared, last pointer returns to N_REQ-1.
- Invariants: grant is never multi-hot. grant is never nonzero in two consecutive cycles belonging to different owners. busy == |grant. owner == index of the set grant bit whenever busy = 1.

Test Plan (QUANTUM = 4, GAP_CYCLES = 1 unless stated):
- Reset then req = 4'b0001 held: grant = 0001 from cycle 1 onward, never drops. hold_count saturates at 3, expired stays 0.
- req = 4'b1111 held from reset: grant 0001 for cycles 1-4, 0000 in cycle 5 with expired = 1, 0010 for cycles 6-9, then 0100 and 1000 in turn, then 0001 again. Each gap is exactly 1 cycle.
- req = 4'b0100 for 2 cycles, then 0, with req[1] asserted in the meantime: grant 0100 for 2 cycles, 1 gap cycle, then 0010. expired stays 0.
- Simultaneous release and quantum: owner 0 drops req on the cycle hold_count = 3 while req[2] = 1: grant -> 0, expired = 0, next grant 0100 after the gap.
- reset asserted low in the middle of a grant to proc2 with req = 4'b1111: grant = 0 on the next cycle. After reset is released, the first grant goes to 0001.
- GAP_CYCLES = 3, req = 4'b0011: between successive grants, grant = 0 for exactly 3 cycles. Grants alternate 0001 and 0010. No cycle ever has more than one grant bit set.

Source files
------------

// File: rtl/bus_grant_controller.sv
// Time-sliced round-robin grant controller for a shared tri-state bus.
// The grant is held while the owner keeps requesting, up to QUANTUM cycles when
// others wait. Every release is followed by GAP_CYCLES idle cycles.
module bus_grant_controller #(
    parameter int N_REQ      = 4,
    parameter int QUANTUM    = 16,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     expired,
    output logic [CNT_W-1:0]         hold_count
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(QUANTUM - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   last_reg;
    logic [GAP_W-1:0]   gap_reg;
    logic [N_REQ-1:0]   grant_reg;
    logic [IDX_W-1:0]   owner_reg;
    logic               busy_reg;
    logic               expired_reg;
    logic [CNT_W-1:0]   hold_reg;

    logic [N_REQ-1:0]   others_next;
    logic [N_REQ-1:0]   win_onehot_next;
    logic [IDX_W-1:0]   win_idx_next;
    logic               win_valid_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_bits
            assign others_next[gi]     = req[gi] && (owner_reg != IDX_W'(gi));
            assign win_onehot_next[gi] = win_valid_next && (win_idx_next == IDX_W'(gi));
        end
    endgenerate

    // Circular search starting just after the last winner; iterating from the
    // farthest candidate down lets the nearest set request overwrite the result.
    always_comb begin
        int idx;
        win_valid_next = 1'b0;
        win_idx_next   = '0;
        idx            = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(last_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[IDX_W'(idx)]) begin
                win_valid_next = 1'b1;
                win_idx_next   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            last_reg    <= IDX_W'(N_REQ - 1);
            gap_reg     <= '0;
            grant_reg   <= '0;
            owner_reg   <= '0;
            busy_reg    <= 1'b0;
            expired_reg <= 1'b0;
            hold_reg    <= '0;
        end else begin
            expired_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (win_valid_next) begin
                        state_reg <= S_GRANT;
                        grant_reg <= win_onehot_next;
                        owner_reg <= win_idx_next;
                        busy_reg  <= 1'b1;
                        hold_reg  <= '0;
                        last_reg  <= win_idx_next;
                    end
                end
                S_GRANT: begin
                    // A voluntary release wins over preemption, so expired stays low.
                    if (!req[owner_reg] || (hold_reg == HOLD_MAX && |others_next)) begin
                        state_reg   <= S_GAP;
                        grant_reg   <= '0;
                        busy_reg    <= 1'b0;
                        hold_reg    <= '0;
                        gap_reg     <= '0;
                        expired_reg <= req[owner_reg];
                    end else if (hold_reg != HOLD_MAX) begin
                        hold_reg <= hold_reg + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        if (win_valid_next) begin
                            state_reg <= S_GRANT;
                            grant_reg <= win_onehot_next;
                            owner_reg <= win_idx_next;
                            busy_reg  <= 1'b1;
                            hold_reg  <= '0;
                            last_reg  <= win_idx_next;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        gap_reg <= gap_reg + GAP_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
                    hold_reg  <= '0;
                end
            endcase
        end
    end

    assign grant      = grant_reg;
    assign owner      = owner_reg;
    assign busy       = busy_reg;
    assign expired    = expired_reg;
    assign hold_count = hold_reg;

endmodule

// File: tb/tb_bus_grant_controller.sv
// Directed bench for bus_grant_controller: two instances (gap 1 and gap 3, quantum 4)
// share stimulus; a behavioural model feeds per-cycle expectations through queues.
module tb_bus_grant_controller;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;

    logic [3:0] grant_a, grant_b;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, busy_b, expired_a, expired_b;
    logic [4:0] hold_a, hold_b;

    always #5 clk = ~clk;

    bus_grant_controller #(.N_REQ(4), .QUANTUM(Q), .GAP_CYCLES(1), .CNT_W(5)) dut_a (
        .clk(clk), .reset(reset), .req(req), .grant(grant_a), .owner(owner_a),
        .busy(busy_a), .expired(expired_a), .hold_count(hold_a)
    );

    bus_grant_controller #(.N_REQ(4), .QUANTUM(Q), .GAP_CYCLES(3), .CNT_W(5)) dut_b (
        .clk(clk), .reset(reset), .req(req), .grant(grant_b), .owner(owner_b),
        .busy(busy_b), .expired(expired_b), .hold_count(hold_b)
    );

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_GRANT = 2'd1;
    localparam logic [1:0] M_GAP   = 2'd2;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] last;
        logic [4:0] hold;
        logic [3:0] gapc;
        logic [3:0] grant;
        logic       expired;
        logic [1:0] owner;
    } model_t;

    model_t ma, mb;
    model_t exp_q_a[$];
    model_t exp_q_b[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // One bus cycle of the reference behaviour; arbitration rotates req so the
    // slot after 'last' lands at bit 0, then takes the lowest set bit.
    function automatic model_t model_step(model_t s, logic [3:0] r, logic rst_n, int gap);
        model_t     n;
        logic [7:0] dbl;
        logic [7:0] sft;
        logic [3:0] rot;
        logic       found;
        logic [1:0] w;
        int         sh;
        n         = s;
        n.expired = 1'b0;
        sh        = int'(s.last) + 1;
        dbl       = {r, r};
        sft       = dbl >> sh;
        rot       = sft[3:0];
        found     = 1'b0;
        w         = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                w     = 2'((sh + j) % 4);
            end
        end
        if (!rst_n) begin
            n      = '0;
            n.last = 2'd3;
            return n;
        end
        case (s.st)
            M_IDLE, M_GAP: begin
                if (s.st == M_GAP && s.gapc != 4'(gap - 1)) begin
                    n.gapc = s.gapc + 4'd1;
                end else if (found) begin
                    n.st    = M_GRANT;
                    n.grant = 4'b0001 << w;
                    n.owner = w;
                    n.last  = w;
                    n.hold  = 5'd0;
                end else begin
                    n.st = M_IDLE;
                end
            end
            M_GRANT: begin
                if (!r[s.owner]) begin
                    n.st = M_GAP; n.grant = 4'b0; n.hold = 5'd0; n.gapc = 4'd0;
                end else if (s.hold == 5'(Q - 1) && (r & ~(4'b0001 << s.owner)) != 4'b0) begin
                    n.st = M_GAP; n.grant = 4'b0; n.hold = 5'd0; n.gapc = 4'd0;
                    n.expired = 1'b1;
                end else if (s.hold != 5'(Q - 1)) begin
                    n.hold = s.hold + 5'd1;
                end
            end
            default: n.st = M_IDLE;
        endcase
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rst_n);
        model_t ea, eb;
        req   = r;
        reset = rst_n;
        ma = model_step(ma, r, rst_n, 1);
        mb = model_step(mb, r, rst_n, 3);
        exp_q_a.push_back(ma);
        exp_q_b.push_back(mb);
        @(posedge clk);
        #1;
        cyc++;
        ea = exp_q_a.pop_front();
        eb = exp_q_b.pop_front();
        check("a_grant",   32'(grant_a),   32'(ea.grant));
        check("a_expired", 32'(expired_a), 32'(ea.expired));
        check("a_busy",    32'(busy_a),    32'(|ea.grant));
        check("a_hold",    32'(hold_a),    32'(ea.hold));
        if (|ea.grant) check("a_owner", 32'(owner_a), 32'(ea.owner));
        check("b_grant",   32'(grant_b),   32'(eb.grant));
        check("b_expired", 32'(expired_b), 32'(eb.expired));
        check("b_busy",    32'(busy_b),    32'(|eb.grant));
        check("b_hold",    32'(hold_b),    32'(eb.hold));
        if (|eb.grant) check("b_owner", 32'(owner_b), 32'(eb.owner));
        check("a_onehot0", 32'($onehot0(grant_a)), 32'd1);
        check("b_onehot0", 32'($onehot0(grant_b)), 32'd1);
        $display("cyc=%0d rst_n=%b req=%b a: grant=%b exp=%b hold=%0d | b: grant=%b exp=%b hold=%0d",
                 cyc, rst_n, r, grant_a, expired_a, hold_a, grant_b, expired_b, hold_b);
    endtask

    initial begin
        ma = '0; ma.last = 2'd3;
        mb = ma;
        req = 4'b0; reset = 1'b0;

        // Reset state
        step(4'b0, 1'b0);
        step(4'b0, 1'b0);
        check("rst_grant", 32'(grant_a), 32'd0);
        check("rst_hold", 32'(hold_a), 32'd0);

        // Lone requester keeps the bus, hold saturates
        for (int i = 1; i <= 10; i++) begin
            step(4'b0001, 1'b1);
            if (i == 1) check("t1_first_grant", 32'(grant_a), 32'h1);
        end
        check("t1_grant", 32'(grant_a), 32'h1);
        check("t1_hold_sat", 32'(hold_a), 32'd3);
        check("t1_expired", 32'(expired_a), 32'd0);

        // All requesting: rotation with quantum preemption
        step(4'b0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            step(4'hF, 1'b1);
            if (i == 4)  check("t2_c4_grant", 32'(grant_a), 32'h1);
            if (i == 5)  check("t2_c5_grant", 32'(grant_a), 32'h0);
            if (i == 5)  check("t2_c5_expired", 32'(expired_a), 32'd1);
            if (i == 6)  check("t2_c6_grant", 32'(grant_a), 32'h2);
            if (i == 11) check("t2_c11_grant", 32'(grant_a), 32'h4);
            if (i == 16) check("t2_c16_grant", 32'(grant_a), 32'h8);
            if (i == 7)  check("t2_b_c7_gap", 32'(grant_b), 32'h0);
            if (i == 8)  check("t2_b_c8_grant", 32'(grant_b), 32'h2);
        end

        // Voluntary release hands over after the gap
        step(4'b0, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0110, 1'b1);
        check("t3_grant2", 32'(grant_a), 32'h4);
        step(4'b0010, 1'b1);
        check("t3_gap", 32'(grant_a), 32'h0);
        step(4'b0010, 1'b1);
        check("t3_next", 32'(grant_a), 32'h2);
        check("t3_expired", 32'(expired_a), 32'd0);

        // Release coinciding with quantum end: no expired pulse
        step(4'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step(4'b0101, 1'b1);
        check("t4_hold3", 32'(hold_a), 32'd3);
        step(4'b0100, 1'b1);
        check("t4_release", 32'(grant_a), 32'h0);
        check("t4_no_expired", 32'(expired_a), 32'd0);
        step(4'b0100, 1'b1);
        check("t4_next", 32'(grant_a), 32'h4);

        // Reset in the middle of a grant to proc2
        step(4'b0, 1'b0);
        step(4'b0100, 1'b1);
        step(4'hF, 1'b1);
        check("t5_proc2", 32'(grant_a), 32'h4);
        step(4'hF, 1'b0);
        check("t5_reset_grant", 32'(grant_a), 32'h0);
        step(4'hF, 1'b1);
        check("t5_after_reset", 32'(grant_a), 32'h1);

        // Two requesters, gap of 3 on dut_b
        step(4'b0, 1'b0);
        for (int i = 1; i <= 24; i++) begin
            step(4'b0011, 1'b1);
            if (i == 5)  check("t6_b_gap_first", 32'(grant_b), 32'h0);
            if (i == 8)  check("t6_b_proc1", 32'(grant_b), 32'h2);
            if (i == 14) check("t6_b_gap_last", 32'(grant_b), 32'h0);
            if (i == 15) check("t6_b_proc0", 32'(grant_b), 32'h1);
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 80; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 19) != 0));
            if ($urandom_range(0, 3) != 0) step(req, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
